// File: rtl/font_loader.sv
// font_loader: packs 16 stream bytes per glyph and writes glyphs to font memory; FONT_LOADER_CKSUM_EN adds a per-glyph XOR checksum byte.
// Latency: wr_en_o rises one cycle after the last byte of a glyph is accepted.
// Backpressure: byte_ready_o is high only in COLLECT, so bytes are held off while idle and during each write cycle.
module font_loader #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 128,
    parameter int ROW_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   nchars_i,
    input  logic [ROW_WIDTH-1:0]  byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [0:DATA_WIDTH-1] wr_data_o,
    output logic                  busy_o,
`ifdef FONT_LOADER_CKSUM_EN
    output logic                  cksum_err_o,
`endif
    output logic                  done_o
);

    localparam int NROWS  = DATA_WIDTH / ROW_WIDTH;
`ifdef FONT_LOADER_CKSUM_EN
    localparam int NBYTES = NROWS + 1;
`else
    localparam int NBYTES = NROWS;
`endif
    localparam int RW = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   left_q, left_d;
    logic [0:DATA_WIDTH-1] glyph_q, glyph_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [0:DATA_WIDTH-1] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
`ifdef FONT_LOADER_CKSUM_EN
    logic [ROW_WIDTH-1:0]  cksum_q, cksum_d;
    logic                  err_q, err_d;
`endif

    logic                  accept;
    logic                  last_glyph;
    logic [0:DATA_WIDTH-1] glyph_shift;

    assign accept      = byte_valid_i && (state_q == COLLECT);
    assign last_glyph  = (left_q == (ADDR_WIDTH+1)'(1));
    // Earlier rows drift toward bit 0, so the first byte ends up top-left.
    assign glyph_shift = {glyph_q[ROW_WIDTH:DATA_WIDTH-1], byte_i};

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        addr_d    = addr_q;
        left_d    = left_q;
        glyph_d   = glyph_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
`ifdef FONT_LOADER_CKSUM_EN
        cksum_d   = cksum_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d  = base_addr_i;
                    left_d  = (nchars_i == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : nchars_i;
                    row_d   = '0;
                    state_d = COLLECT;
`ifdef FONT_LOADER_CKSUM_EN
                    cksum_d = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            COLLECT: begin
                if (accept) begin
`ifdef FONT_LOADER_CKSUM_EN
                    if (row_q < RW'(NROWS)) begin
                        glyph_d = glyph_shift;
                        cksum_d = cksum_q ^ byte_i;
                        row_d   = row_q + RW'(1);
                    end else begin
                        row_d   = '0;
                        cksum_d = '0;
                        if (byte_i == cksum_q) begin
                            wr_addr_d = addr_q;
                            wr_data_d = glyph_q;
                            state_d   = WRITE;
                        end else begin
                            // Corrupt glyph: drop it but keep the address sequence intact.
                            err_d  = 1'b1;
                            addr_d = addr_q + ADDR_WIDTH'(1);
                            left_d = left_q - (ADDR_WIDTH+1)'(1);
                            if (last_glyph) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
`else
                    glyph_d = glyph_shift;
                    if (row_q == RW'(NROWS-1)) begin
                        row_d     = '0;
                        wr_addr_d = addr_q;
                        wr_data_d = glyph_shift;
                        state_d   = WRITE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
`endif
                end
            end
            WRITE: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                left_d = left_q - (ADDR_WIDTH+1)'(1);
                if (last_glyph) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            row_q     <= '0;
            addr_q    <= '0;
            left_q    <= '0;
            glyph_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
`ifdef FONT_LOADER_CKSUM_EN
            cksum_q   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            row_q     <= row_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            glyph_q   <= glyph_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
`ifdef FONT_LOADER_CKSUM_EN
            cksum_q   <= cksum_d;
            err_q     <= err_d;
`endif
        end
    end

    assign byte_ready_o = (state_q == COLLECT);
    assign wr_en_o      = (state_q == WRITE);
    assign busy_o       = (state_q != IDLE);
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign done_o       = done_q;
`ifdef FONT_LOADER_CKSUM_EN
    assign cksum_err_o  = err_q;
`endif

endmodule

// File: tb/tb_font_loader.sv
// Directed bench for font_loader (default build): reset, single/multi glyph loads,
// address wrap, full 128-glyph load, stalls with ignored start, and mid-load reset.
`timescale 1ns/1ps
module tb_font_loader;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         start_i;
    logic [6:0]   base_addr_i;
    logic [7:0]   nchars_i;
    logic [7:0]   byte_i;
    logic         byte_valid_i;
    logic         byte_ready_o;
    logic         wr_en_o;
    logic [6:0]   wr_addr_o;
    logic [0:127] wr_data_o;
    logic         busy_o;
    logic         done_o;

    font_loader dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .nchars_i     (nchars_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #4.897 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    int wr_cnt    = 0;
    int done_cnt  = 0;
    int rdy_in_wr = 0;
    logic [6:0]   addr_log[$];
    logic [127:0] data_log[$];

    always @(negedge clk_i) begin
        if (wr_en_o) begin
            wr_cnt++;
            addr_log.push_back(wr_addr_o);
            data_log.push_back(wr_data_o);
            if (byte_ready_o) rdy_in_wr++;
        end
        if (done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Row r of a glyph carries seed+r; row r sits at value bits [127-8r -: 8].
    function automatic logic [127:0] glyph_val(input logic [7:0] seed);
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < 16; r++) v[127-8*r -: 8] = seed + 8'(r);
        return v;
    endfunction

    // Entered and left at a negedge; the byte is accepted at the posedge in between.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) chk("ready_timeout", {127'd0, byte_ready_o}, 128'd1);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_start(input logic [6:0] base, input logic [7:0] nch);
        start_i     = 1'b1;
        base_addr_i = base;
        nchars_i    = nch;
        @(negedge clk_i);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        byte_valid_i = 1'b0;
        while (!done_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, {127'd0, done_o}, 128'd1);
        @(negedge clk_i);
    endtask

    int w0, d0, r0, bad_a, bad_d;

    initial begin
        rstn_i       = 1'b0;
        start_i      = 1'b0;
        base_addr_i  = '0;
        nchars_i     = '0;
        byte_i       = '0;
        byte_valid_i = 1'b0;
        #20;
        chk("rst_ready", {127'd0, byte_ready_o}, 128'd0);
        chk("rst_wr_en", {127'd0, wr_en_o}, 128'd0);
        chk("rst_busy",  {127'd0, busy_o}, 128'd0);
        chk("rst_done",  {127'd0, done_o}, 128'd0);
        chk("rst_addr",  {121'd0, wr_addr_o}, 128'd0);
        chk("rst_data",  wr_data_o, 128'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Valid high while idle must not be consumed.
        byte_i = 8'hAA; byte_valid_i = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", {127'd0, byte_ready_o}, 128'd0);
        @(negedge clk_i);
        byte_valid_i = 1'b0;

        // Single glyph at 0x41, bytes 0x00..0x0F back-to-back.
        w0 = wr_cnt;
        do_start(7'h41, 8'd1);
        chk("t1_busy",  {127'd0, busy_o}, 128'd1);
        chk("t1_ready", {127'd0, byte_ready_o}, 128'd1);
        for (int r = 0; r < 16; r++) send_byte(8'(r));
        chk("t1_wr_en_lat", {127'd0, wr_en_o}, 128'd1);
        chk("t1_ready_wr",  {127'd0, byte_ready_o}, 128'd0);
        chk("t1_addr",      {121'd0, wr_addr_o}, 128'h41);
        chk("t1_data",      wr_data_o, 128'h000102030405060708090A0B0C0D0E0F);
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        chk("t1_done", {127'd0, done_o}, 128'd1);
        chk("t1_idle", {127'd0, busy_o}, 128'd0);
        chk("t1_wr_en_off", {127'd0, wr_en_o}, 128'd0);
        @(negedge clk_i);
        chk("t1_done_pulse", {127'd0, done_o}, 128'd0);
        chk("t1_addr_hold",  {121'd0, wr_addr_o}, 128'h41);
        chk("t1_data_hold",  wr_data_o, 128'h000102030405060708090A0B0C0D0E0F);
        chk("t1_wr_count",   128'(wr_cnt - w0), 128'd1);

        // Two glyphs of 0xFF starting at 0x7F: address wraps to 0x00.
        w0 = wr_cnt; d0 = done_cnt;
        do_start(7'h7F, 8'd2);
        for (int i = 0; i < 32; i++) send_byte(8'hFF);
        wait_done("t2_done_seen");
        @(negedge clk_i);
        chk("t2_wr_count", 128'(wr_cnt - w0), 128'd2);
        chk("t2_addr0",    {121'd0, addr_log[w0]}, 128'h7F);
        chk("t2_addr1",    {121'd0, addr_log[w0+1]}, 128'h00);
        chk("t2_data0",    data_log[w0], {128{1'b1}});
        chk("t2_data1",    data_log[w0+1], {128{1'b1}});
        chk("t2_done_cnt", 128'(done_cnt - d0), 128'd1);

        // nchars 0 loads all 128 glyphs starting at 0x10.
        w0 = wr_cnt; d0 = done_cnt;
        do_start(7'h10, 8'd0);
        for (int g = 0; g < 128; g++)
            for (int r = 0; r < 16; r++) send_byte(8'(g + r));
        wait_done("t3_done_seen");
        @(negedge clk_i);
        chk("t3_wr_count", 128'(wr_cnt - w0), 128'd128);
        bad_a = 0; bad_d = 0;
        for (int i = 0; i < 128; i++) begin
            if (w0 + i < addr_log.size()) begin
                if (addr_log[w0+i] !== 7'(8'h10 + 8'(i))) bad_a++;
                if (data_log[w0+i] !== glyph_val(8'(i))) bad_d++;
            end
        end
        chk("t3_addr_seq", 128'(bad_a), 128'd0);
        chk("t3_data_seq", 128'(bad_d), 128'd0);
        chk("t3_done_cnt", 128'(done_cnt - d0), 128'd1);

        // Random stalls plus a start pulse mid-load that must be ignored.
        w0 = wr_cnt; d0 = done_cnt; r0 = rdy_in_wr;
        do_start(7'h20, 8'd3);
        for (int g = 0; g < 3; g++) begin
            for (int r = 0; r < 16; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    byte_valid_i = 1'b0;
                    @(negedge clk_i);
                end
                if (g == 1 && r == 5) begin
                    start_i = 1'b1; base_addr_i = 7'h55; nchars_i = 8'd5;
                end
                send_byte(8'(8'h30 + 8'(16*g) + 8'(r)));
                start_i = 1'b0;
            end
        end
        wait_done("t4_done_seen");
        repeat (3) @(negedge clk_i);
        chk("t4_wr_count", 128'(wr_cnt - w0), 128'd3);
        chk("t4_addr0", {121'd0, addr_log[w0]},   128'h20);
        chk("t4_addr2", {121'd0, addr_log[w0+2]}, 128'h22);
        chk("t4_data0", data_log[w0],   glyph_val(8'h30));
        chk("t4_data1", data_log[w0+1], glyph_val(8'h40));
        chk("t4_data2", data_log[w0+2], glyph_val(8'h50));
        chk("t4_ready_in_write", 128'(rdy_in_wr - r0), 128'd0);
        chk("t4_done_cnt", 128'(done_cnt - d0), 128'd1);

        // Reset after 9 bytes: outputs clear at once, partial glyph is never written.
        w0 = wr_cnt;
        do_start(7'h05, 8'd1);
        for (int r = 0; r < 9; r++) send_byte(8'hC0 + 8'(r));
        byte_valid_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        chk("t5_rst_busy",  {127'd0, busy_o}, 128'd0);
        chk("t5_rst_ready", {127'd0, byte_ready_o}, 128'd0);
        chk("t5_rst_addr",  {121'd0, wr_addr_o}, 128'd0);
        chk("t5_rst_data",  wr_data_o, 128'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        byte_valid_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("t5_wait_start", {127'd0, busy_o}, 128'd0);
        chk("t5_no_write", 128'(wr_cnt - w0), 128'd0);
        do_start(7'h06, 8'd1);
        for (int r = 0; r < 16; r++) send_byte(8'hA0 + 8'(r));
        chk("t5_wr_en", {127'd0, wr_en_o}, 128'd1);
        chk("t5_addr",  {121'd0, wr_addr_o}, 128'h06);
        chk("t5_data",  wr_data_o, glyph_val(8'hA0));
        wait_done("t5_done_seen");
        chk("t5_wr_count", 128'(wr_cnt - w0), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/font_loader.md
FONT_LOADER -- requirements
Module: font_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, glyph address width (128 characters).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, glyph width (8x16 pixels).
REQ-003 SHALL have parameter ROW_WIDTH, default 8, pixels per glyph row and bits per stream byte.
REQ-004 SHALL have port clk_i  input  1  single clock, 102.1MHz.
REQ-005 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  one-cycle load command.
REQ-007 SHALL have port base_addr_i  input  ADDR_WIDTH  first glyph address, sampled on accepted start.
REQ-008 SHALL have port nchars_i  input  ADDR_WIDTH+1  glyph count, sampled on accepted start; 0 means 128.
REQ-009 SHALL have port byte_i  input  ROW_WIDTH  stream byte, one glyph row, bit 7 = leftmost pixel.
REQ-010 SHALL have port byte_valid_i  input  1  byte_i valid.
REQ-011 SHALL have port byte_ready_o  output  1  loader accepts byte_i.
REQ-012 SHALL have port wr_en_o  output  1  one-cycle write strobe to font memory.
REQ-013 SHALL have port wr_addr_o  output  ADDR_WIDTH  write address (ASCII code).
REQ-014 SHALL have port wr_data_o  output  [0:DATA_WIDTH-1]  glyph, bit 0 = top-left pixel.
REQ-015 SHALL have port busy_o  output  1  load in progress.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse after last glyph written.

Function
REQ-017 SHALL implement states IDLE, COLLECT, WRITE; byte accepted only when byte_valid_i and byte_ready_o both high.
REQ-018 IDLE: start_i high SHALL latch base_addr_i and nchars_i, go to COLLECT next cycle; byte_ready_o low, busy_o low.
REQ-019 start_i while busy_o high SHALL be ignored with no effect on the load in progress.
REQ-020 COLLECT: byte_ready_o SHALL be high; k-th accepted byte (k=0..15) SHALL occupy wr_data_o bits [8k:8k+7], byte bit 7 at bit 8k.
REQ-021 After the 16th accepted byte SHALL go to WRITE; in WRITE byte_ready_o SHALL be low and wr_en_o high for exactly one cycle with current address and assembled glyph.
REQ-022 After WRITE, address SHALL increment modulo 2^ADDR_WIDTH (127 wraps to 0) and remaining count decrement; nonzero returns to COLLECT, zero returns to IDLE with done_o high one cycle.
REQ-023 Write latency SHALL be exactly one cycle from acceptance of the 16th byte to wr_en_o high.
REQ-024 byte_valid_i in IDLE or WRITE SHALL not be consumed; stalls (valid low) in COLLECT SHALL hold the row counter.
REQ-025 wr_addr_o and wr_data_o SHALL hold last written values outside WRITE.

Reset
REQ-026 rstn_i low SHALL asynchronously force IDLE, byte_ready_o=0, wr_en_o=0, busy_o=0, done_o=0, wr_addr_o=0, wr_data_o=0, row counter=0.
REQ-027 Reset mid-load SHALL abandon the partial glyph with no write; after release, loader SHALL wait for a fresh start_i.

Configuration
REQ-028 Macro FONT_LOADER_CKSUM_EN defined: each glyph SHALL be followed by a 17th byte equal to XOR of its 16 bytes; accepted in COLLECT.
REQ-029 With FONT_LOADER_CKSUM_EN, mismatch SHALL skip WRITE for that glyph, still advance address and count, and set sticky output cksum_err_o (cleared by reset or accepted start).
REQ-030 Without FONT_LOADER_CKSUM_EN, no checksum byte, no cksum_err_o port; glyph written after 16 bytes.

Verification
REQ-031 start, base 0x41, nchars 1, bytes 0x00..0x0F back-to-back -> one wr_en_o at addr 0x41, data 0x000102...0F, done_o one cycle later in IDLE.
REQ-032 base 0x7F, nchars 2, 32 bytes 0xFF -> writes at 0x7F then 0x00, data all ones, single done_o.
REQ-033 nchars 0 -> exactly 128 writes, addresses base..base+127 mod 128, then done_o.
REQ-034 byte_valid_i toggled randomly, start_i pulsed mid-load -> glyph data unchanged, start ignored, byte_ready_o low during each WRITE cycle.
REQ-035 rstn_i asserted after 9 bytes -> outputs zero immediately, no write; new start with 16 bytes writes correctly.
REQ-036 With FONT_LOADER_CKSUM_EN, checksum byte 0x00 for bytes 0x01,0x00x15 -> no write, cksum_err_o=1, address still advances.
